vend_dispense_ctrl: RTL and testbench

//   Back-end sequencer for the vending machine FSM: accepts a vend or refund command.

---
 rtl/vend_dispense_if.sv | 24 ++
 rtl/vend_dispense_ctrl.sv | 93 +++++++++
 tb/tb_vend_dispense_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vend_dispense_if.sv
// vend_dispense_if: command inputs and dispense/status outputs of the vend dispense sequencer
interface vend_dispense_if;
  logic       vend_req;
  logic [1:0] vend_item;
  logic [2:0] vend_cng;
  logic       rtn_req;
  logic [2:0] rtn_amt;
  logic       restock;
  logic [1:0] restock_item;
  logic       busy;
  logic [3:0] motor;
  logic       coin_eject;
  logic [3:0] item_available;
  logic       done;
  logic       err_empty;
  modport master (
    output vend_req, vend_item, vend_cng, rtn_req, rtn_amt, restock, restock_item,
    input  busy, motor, coin_eject, item_available, done, err_empty
  );
  modport slave (
    input  vend_req, vend_item, vend_cng, rtn_req, rtn_amt, restock, restock_item,
    output busy, motor, coin_eject, item_available, done, err_empty
  );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: vend/refund sequencer driving the release motor, coin ejector and per-item stock
module vend_dispense_ctrl #(
  parameter int STOCK_W      = 4,
  parameter int STOCK_INIT   = 9,
  parameter int MOTOR_CYCLES = 8,
  parameter int COIN_GAP     = 2
) (
  input logic            clk,
  input logic            rst_n,
  vend_dispense_if.slave bus
);
  localparam int TW = $clog2(MOTOR_CYCLES + COIN_GAP + 1);
  typedef enum logic [2:0] {IDLE, MOTOR, COIN_HI, COIN_LO, DONE} state_t;
  state_t               state_q, state_d;
  logic [1:0]           item_q, item_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [STOCK_W-1:0]   stock_q [4];
  logic [STOCK_W-1:0]   stock_d [4];
  logic [3:0]           avail_q, motor_q;
  logic                 busy_q, coin_q, done_q, err_q, err_d;
  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    stock_d = stock_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE:
        if (bus.vend_req) begin
          if (stock_q[bus.vend_item] != '0) begin
            state_d = MOTOR;
            item_d  = bus.vend_item;
            cnt_d   = bus.vend_cng;
            tmr_d   = TW'(MOTOR_CYCLES - 1);
            stock_d[bus.vend_item] = stock_q[bus.vend_item] - STOCK_W'(1);
          end else
            err_d = 1'b1;
        end else if (bus.rtn_req) begin
          cnt_d   = bus.rtn_amt;
          state_d = bus.rtn_amt != 3'd0 ? COIN_HI : DONE;
        end
      MOTOR:
        if (tmr_q == '0) state_d = cnt_q != 3'd0 ? COIN_HI : DONE;
        else tmr_d = tmr_q - TW'(1);
      COIN_HI: begin
        cnt_d   = cnt_q - 3'd1;
        tmr_d   = TW'(COIN_GAP - 1);
        state_d = cnt_q == 3'd1 ? DONE : COIN_LO;
      end
      COIN_LO:
        if (tmr_q == '0) state_d = COIN_HI;
        else tmr_d = tmr_q - TW'(1);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // applied last so a same-item restock overrides the vend decrement
    if (bus.restock) stock_d[bus.restock_item] = STOCK_W'(STOCK_INIT);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      item_q  <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      for (int i = 0; i < 4; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      avail_q <= 4'hF;
      motor_q <= '0;
      busy_q  <= 1'b0;
      coin_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      stock_q <= stock_d;
      for (int i = 0; i < 4; i++) avail_q[i] <= stock_q[i] != '0;
      motor_q <= state_d == MOTOR ? 4'b0001 << item_d : 4'b0000;
      busy_q  <= state_d != IDLE;
      coin_q  <= state_d == COIN_HI;
      done_q  <= state_d == DONE;
      err_q   <= err_d;
    end
  assign bus.busy           = busy_q;
  assign bus.motor          = motor_q;
  assign bus.coin_eject     = coin_q;
  assign bus.item_available = avail_q;
  assign bus.done           = done_q;
  assign bus.err_empty      = err_q;
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: scoreboard bench with a timeline reference model of the dispense sequencer
module tb_vend_dispense_ctrl;
  localparam int MC = 8, CG = 2, SI = 9;
  localparam int K_MOT = 0, K_COIN = 1, K_DONE = 2, K_ERR = 3;
  typedef struct {int kind; int val; int cyc;} ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  ev_t exp_q[$];
  int stock[4];
  int done_cyc = -1;
  int busy_from = 0;
  logic [3:0] prev_motor = '0;
  vend_dispense_if b();
  vend_dispense_ctrl #(.STOCK_W(4), .STOCK_INIT(SI), .MOTOR_CYCLES(MC), .COIN_GAP(CG))
    dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at cyc=%0d", name, act, exp, cyc);
    end
  endfunction
  function automatic void push(int k, int v, int c);
    ev_t e;
    e.kind = k; e.val = v; e.cyc = c;
    exp_q.push_back(e);
  endfunction
  function automatic void got(int k, int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got kind=%0d val=%0d cyc=%0d exp none", k, v, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.val != v || e.cyc != cyc) begin
      errors++;
      $display("FAIL event got kind=%0d val=%0d cyc=%0d exp kind=%0d val=%0d cyc=%0d",
               k, v, cyc, e.kind, e.val, e.cyc);
    end
  endfunction
  // coins every CG+1 cycles from s, done per the latency rule
  function automatic void coins(int s, int n);
    for (int k = 0; k < n; k++) push(K_COIN, 1, s + k * (CG + 1));
    done_cyc = (n == 0) ? s : s + n + (n - 1) * CG;
    push(K_DONE, 1, done_cyc);
  endfunction
  function automatic void model_cmd(int t, bit vr, int vi, int vc, bit rr, int ra, bit rs, int ri);
    if (t > done_cyc) begin
      if (vr) begin
        if (stock[vi] == 0) push(K_ERR, 1, t + 1);
        else begin
          stock[vi]--;
          busy_from = t + 1;
          push(K_MOT, 1 << vi, t + 1);
          push(K_MOT, 0, t + 1 + MC);
          coins(t + 1 + MC, vc);
        end
      end else if (rr) begin
        busy_from = t + 1;
        coins(t + 1, ra);
      end
    end
    if (rs) stock[ri] = SI;
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < 4; i++) stock[i] = SI;
    done_cyc = -1;
    busy_from = 0;
    exp_q.delete();
  endfunction
  function automatic int exp_avail();
    int a = 0;
    for (int i = 0; i < 4; i++) if (stock[i] != 0) a |= 1 << i;
    return a;
  endfunction
  always @(negedge clk)
    if (rst_n) begin
      chk("busy", int'(b.busy), int'(cyc >= busy_from && cyc <= done_cyc));
      chk("motor_coin_excl", int'(b.motor != 4'd0 && b.coin_eject), 0);
      if (b.motor != prev_motor) got(K_MOT, int'(b.motor));
      if (b.coin_eject) got(K_COIN, 1);
      if (b.done) got(K_DONE, 1);
      if (b.err_empty) got(K_ERR, 1);
      prev_motor = b.motor;
    end else
      prev_motor = '0;
  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wait_idle();
    while (cyc <= done_cyc) tick(1);
  endtask
  task automatic issue(bit vr, int vi, int vc, bit rr, int ra, bit rs, int ri);
    b.vend_req = vr; b.vend_item = 2'(vi); b.vend_cng = 3'(vc);
    b.rtn_req = rr; b.rtn_amt = 3'(ra);
    b.restock = rs; b.restock_item = 2'(ri);
    model_cmd(cyc, vr, vi, vc, rr, ra, rs, ri);
    tick(1);
    b.vend_req = 1'b0; b.rtn_req = 1'b0; b.restock = 1'b0;
  endtask
  task automatic check_idle_outputs(string tag);
    chk({tag, "_motor"}, int'(b.motor), 0);
    chk({tag, "_coin"}, int'(b.coin_eject), 0);
    chk({tag, "_busy"}, int'(b.busy), 0);
    chk({tag, "_done"}, int'(b.done), 0);
    chk({tag, "_err"}, int'(b.err_empty), 0);
    chk({tag, "_avail"}, int'(b.item_available), 15);
  endtask
  task automatic settle_and_check_avail(string name);
    wait_idle();
    tick(3);
    chk(name, int'(b.item_available), exp_avail());
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    b.vend_req = 0; b.vend_item = 0; b.vend_cng = 0; b.rtn_req = 0; b.rtn_amt = 0;
    b.restock = 0; b.restock_item = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick(2);
    issue(1, 0, 3, 0, 0, 0, 0);
    settle_and_check_avail("t1_avail");
    chk("t1_stock0", stock[0], 8);
    issue(0, 0, 0, 1, 4, 0, 0);
    wait_idle();
    issue(0, 0, 0, 1, 0, 0, 0);
    wait_idle();
    for (int i = 0; i < 9; i++) begin
      issue(1, 3, 0, 0, 0, 0, 0);
      wait_idle();
    end
    settle_and_check_avail("t3_avail_empty");
    chk("t3_avail_value", int'(b.item_available), 7);
    issue(1, 3, 2, 0, 0, 0, 0);
    tick(3);
    issue(0, 0, 0, 0, 0, 1, 3);
    settle_and_check_avail("t3_avail_restock");
    issue(1, 1, 1, 1, 5, 0, 0);
    tick(2);
    issue(1, 0, 2, 0, 0, 0, 0);
    wait_idle();
    issue(1, 2, 0, 0, 0, 1, 2);
    settle_and_check_avail("t5_avail");
    chk("t5_stock2", stock[2], SI);
    issue(1, 1, 5, 0, 0, 0, 0);
    t = cyc - 1;
    while (cyc < t + 1 + MC + 1) tick(1);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("midreset");
    model_reset();
    tick(2);
    #2 rst_n = 1'b1;
    tick(1);
    check_idle_outputs("post_reset");
    tick(30);
    for (int n = 0; n < 150; n++) begin
      int sel = $urandom_range(0, 9);
      bit rs = ($urandom_range(0, 7) == 0);
      int vi = $urandom_range(0, 3);
      if (sel < 6) issue(1, vi, $urandom_range(0, 7), sel == 5, $urandom_range(0, 7), rs, $urandom_range(0, 3));
      else if (sel < 9) issue(0, vi, 0, 1, $urandom_range(0, 7), rs, $urandom_range(0, 3));
      else issue(0, vi, 0, 0, 0, 1, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) wait_idle();
      else tick($urandom_range(0, 25));
    end
    settle_and_check_avail("rand_avail");
    tick(5);
    chk("pending_events", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
